// File: rtl/mont_from_domain.sv
// mont_from_domain
// Word-serial Montgomery reduction with the multiplier fixed to 1:
// result = a * R^-1 mod n, where R = 2^WIDTH. It takes an operand out of the
// Montgomery domain at the tail of the exponentiation datapath.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   go      start strobe, sampled only while idle
//   a       operand in Montgomery form (a < n)
//   n       odd modulus, n > 2^(WIDTH-1)
//   n_inv   -n^-1 mod 2^W
//   result  a * R^-1 mod n, registered, held until the next completion
//   busy    high from the go edge until done
//   done    one-cycle pulse when result becomes valid
//
// Latency: go edge is edge 0, done is high after edge NW*(NW+2) + NW + 1.
// WIDTH must be a multiple of W with at least two words.
module mont_from_domain #(
    parameter int WIDTH = 4096,
    parameter int W     = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] n,
    input  logic [W-1:0]     n_inv,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int NW = WIDTH / W;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MCALC = 3'd1,
        S_ACC   = 3'd2,
        S_TOP   = 3'd3,
        S_SUB   = 3'd4,
        S_FIN   = 3'd5
    } state_e;

    state_e           state_q, state_d;
    // t keeps one extra top bit; its low WIDTH bits are used as a word
    // shift register so the active word is always at bit 0.
    logic [WIDTH:0]   t_q, t_d;
    logic [WIDTH-1:0] d_q, d_d;
    // n rotates one word per ACC/SUB cycle and is back in place afterwards.
    logic [WIDTH-1:0] n_q, n_d;
    logic [W-1:0]     n_inv_q, n_inv_d;
    logic [W-1:0]     m_q, m_d;
    logic [W-1:0]     carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    i_q, i_d;
    logic [CW-1:0]    j_q, j_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [W-1:0]     mul_a_s, mul_b_s;
    logic [2*W-1:0]   prod_s;
    logic [2*W-1:0]   acc_sum_s;
    logic [W:0]       top_sum_s;
    logic [W:0]       sub_s;

    // Shared W x W multiplier: m computation in MCALC, m * n_word in ACC.
    always_comb begin
        mul_a_s = m_q;
        mul_b_s = n_q[W-1:0];
        if (state_q == S_MCALC) begin
            mul_a_s = t_q[W-1:0];
            mul_b_s = n_inv_q;
        end else begin
            mul_a_s = m_q;
            mul_b_s = n_q[W-1:0];
        end
    end

    // Word arithmetic: multiply-accumulate, top-word carry fold, subtract.
    always_comb begin
        prod_s    = {{W{1'b0}}, mul_a_s} * {{W{1'b0}}, mul_b_s};
        // Bounded by 2^(2W)-1, so the 2W-bit sum cannot overflow.
        acc_sum_s = prod_s + {{W{1'b0}}, t_q[W-1:0]} + {{W{1'b0}}, carry_q};
        top_sum_s = {{W{1'b0}}, t_q[WIDTH]} + {1'b0, carry_q};
        sub_s     = {1'b0, t_q[W-1:0]} - {1'b0, n_q[W-1:0]} - {{W{1'b0}}, borrow_q};
    end

    // Next-state and datapath update for the reduction sequence.
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        d_d      = d_q;
        n_d      = n_q;
        n_inv_d  = n_inv_q;
        m_d      = m_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        i_d      = i_q;
        j_d      = j_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    n_d     = n;
                    n_inv_d = n_inv;
                    t_d     = {1'b0, a};
                    i_d     = {CW{1'b0}};
                    busy_d  = 1'b1;
                    state_d = S_MCALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MCALC: begin
                m_d     = prod_s[W-1:0];
                j_d     = {CW{1'b0}};
                carry_d = {W{1'b0}};
                state_d = S_ACC;
            end
            S_ACC: begin
                // Sum enters at the top and the array shifts down one word;
                // word 0's sum (zero by construction) is dropped in TOP.
                t_d     = {t_q[WIDTH], acc_sum_s[W-1:0], t_q[WIDTH-1:W]};
                n_d     = {n_q[W-1:0], n_q[WIDTH-1:W]};
                carry_d = acc_sum_s[2*W-1:W];
                j_d     = j_q + {{(CW-1){1'b0}}, 1'b1};
                if (j_q == CW'(NW - 1)) begin
                    state_d = S_TOP;
                end else begin
                    state_d = S_ACC;
                end
            end
            S_TOP: begin
                // Shift out the zero word and place t_top + carry on top.
                t_d = {top_sum_s, t_q[WIDTH-1:W]};
                i_d = i_q + {{(CW-1){1'b0}}, 1'b1};
                if (i_q == CW'(NW - 1)) begin
                    j_d      = {CW{1'b0}};
                    borrow_d = 1'b0;
                    state_d  = S_SUB;
                end else begin
                    state_d = S_MCALC;
                end
            end
            S_SUB: begin
                d_d      = {sub_s[W-1:0], d_q[WIDTH-1:W]};
                borrow_d = sub_s[W];
                t_d      = {t_q[WIDTH], t_q[W-1:0], t_q[WIDTH-1:W]};
                n_d      = {n_q[W-1:0], n_q[WIDTH-1:W]};
                j_d      = j_q + {{(CW-1){1'b0}}, 1'b1};
                if (j_q == CW'(NW - 1)) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_SUB;
                end
            end
            S_FIN: begin
                // t >= n when the top bit is set or the subtraction did not borrow.
                if (t_q[WIDTH] || !borrow_q) begin
                    result_d = d_q;
                end else begin
                    result_d = t_q[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            t_q      <= {(WIDTH + 1){1'b0}};
            d_q      <= {WIDTH{1'b0}};
            n_q      <= {WIDTH{1'b0}};
            n_inv_q  <= {W{1'b0}};
            m_q      <= {W{1'b0}};
            carry_q  <= {W{1'b0}};
            borrow_q <= 1'b0;
            i_q      <= {CW{1'b0}};
            j_q      <= {CW{1'b0}};
            result_q <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            d_q      <= d_d;
            n_q      <= n_d;
            n_inv_q  <= n_inv_d;
            m_q      <= m_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            i_q      <= i_d;
            j_q      <= j_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
